// File: rtl/rmt_recovery_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rmt_recovery_ctrl_pkg
// Description : Shared sizing constants, FSM state type and lane packing
//               helpers for the RMT recovery controller.
// Revision    : 1.0 - initial release
// ============================================================================
package rmt_recovery_ctrl_pkg;

    localparam int LREG_COUNT = 32;
    localparam int LREG_W     = 5;
    localparam int PREG_W     = 7;
    localparam int WR_PORTS   = 8;
    localparam int RN_WIDTH   = 4;
    localparam int NBEATS     = LREG_COUNT / WR_PORTS;
    localparam int BEAT_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        COPY = 1'b1
    } state_t;

    function automatic int lreg_lsb(input int lane);
        return lane * LREG_W;
    endfunction

    function automatic int preg_lsb(input int lane);
        return lane * PREG_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rmt_wport_mux.sv
`default_nettype none
// ============================================================================
// Module      : rmt_wport_mux
// Description : One RMT write lane: selects the AMT copy beat or the rename
//               update for this port.
// Revision    : 1.0 - initial release
// ============================================================================
module rmt_wport_mux
    import rmt_recovery_ctrl_pkg::*;
(
    input  logic              copy_sel,
    input  logic              rn_en,
    input  logic              rn_we,
    input  logic [LREG_W-1:0] rn_lreg,
    input  logic [PREG_W-1:0] rn_preg,
    input  logic [LREG_W-1:0] copy_addr,
    input  logic [PREG_W-1:0] copy_data,
    output logic              we,
    output logic [LREG_W-1:0] waddr,
    output logic [PREG_W-1:0] wdata
);

    always_comb begin
        if (copy_sel) begin
            we    = 1'b1;
            waddr = copy_addr;
            wdata = copy_data;
        end else begin
            // rn_en drops on the recovery cycle so wrong-path renames never land
            we    = rn_we & rn_en;
            waddr = rn_lreg;
            wdata = rn_preg;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rmt_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rmt_recovery_ctrl
// Description : RMT write-port controller: rename pass-through in IDLE,
//               AMT->RMT bulk copy on recovery. Optional perf counters
//               enabled by RMT_RECOVER_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rmt_recovery_ctrl
    import rmt_recovery_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         recover_i,
    input  logic [RN_WIDTH-1:0]          rn_we_i,
    input  logic [RN_WIDTH*LREG_W-1:0]   rn_lreg_i,
    input  logic [RN_WIDTH*PREG_W-1:0]   rn_preg_i,
    output logic [WR_PORTS*LREG_W-1:0]   amt_raddr_o,
    input  logic [WR_PORTS*PREG_W-1:0]   amt_rdata_i,
    output logic [WR_PORTS-1:0]          rmt_we_o,
    output logic [WR_PORTS*LREG_W-1:0]   rmt_waddr_o,
    output logic [WR_PORTS*PREG_W-1:0]   rmt_wdata_o,
    output logic                         stall_rename_o,
    output logic                         stall_commit_o,
    output logic                         busy_o,
`ifdef RMT_RECOVER_PERF_EN
    output logic [31:0]                  perf_recover_cnt_o,
    output logic [31:0]                  perf_stall_cnt_o,
`endif
    output logic                         done_o
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic              w_busy;
    logic              w_last;
    logic              w_done;
    logic              w_rn_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (recover_i) begin
                    w_state_nxt = COPY;
                    w_beat_nxt  = '0;
                end
            end
            COPY: begin
                // A new request restarts the copy; the in-flight beat still writes
                if (recover_i) begin
                    w_beat_nxt = '0;
                end else if (w_last) begin
                    w_state_nxt = IDLE;
                    w_beat_nxt  = '0;
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_busy  = (r_state == COPY) && !reset;
        w_last  = (r_beat == BEAT_W'(NBEATS - 1));
        w_done  = w_busy && w_last && !recover_i;
        w_rn_en = !reset && !recover_i;
    end

    assign busy_o         = w_busy;
    assign done_o         = w_done;
    assign stall_commit_o = w_busy;
    assign stall_rename_o = w_busy | recover_i;

    for (genvar k = 0; k < WR_PORTS; k++) begin : g_lane
        logic              w_rn_we;
        logic [LREG_W-1:0] w_rn_lreg;
        logic [PREG_W-1:0] w_rn_preg;
        logic [LREG_W-1:0] w_copy_addr;

        if (k < RN_WIDTH) begin : g_rn
            assign w_rn_we   = rn_we_i[k];
            assign w_rn_lreg = rn_lreg_i[lreg_lsb(k) +: LREG_W];
            assign w_rn_preg = rn_preg_i[preg_lsb(k) +: PREG_W];
        end else begin : g_no_rn
            assign w_rn_we   = 1'b0;
            assign w_rn_lreg = '0;
            assign w_rn_preg = '0;
        end

        assign w_copy_addr = LREG_W'(int'(r_beat) * WR_PORTS + k);
        assign amt_raddr_o[lreg_lsb(k) +: LREG_W] = w_busy ? w_copy_addr : '0;

        rmt_wport_mux u_mux (
            .copy_sel  (w_busy),
            .rn_en     (w_rn_en),
            .rn_we     (w_rn_we),
            .rn_lreg   (w_rn_lreg),
            .rn_preg   (w_rn_preg),
            .copy_addr (w_copy_addr),
            .copy_data (amt_rdata_i[preg_lsb(k) +: PREG_W]),
            .we        (rmt_we_o[k]),
            .waddr     (rmt_waddr_o[lreg_lsb(k) +: LREG_W]),
            .wdata     (rmt_wdata_o[preg_lsb(k) +: PREG_W])
        );
    end

`ifdef RMT_RECOVER_PERF_EN
    logic [31:0] r_perf_recover_cnt;
    logic [31:0] r_perf_stall_cnt;

    // Both counters stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_recover_cnt <= '0;
            r_perf_stall_cnt   <= '0;
        end else begin
            if (recover_i && !(&r_perf_recover_cnt))
                r_perf_recover_cnt <= r_perf_recover_cnt + 32'd1;
            if (w_busy && !(&r_perf_stall_cnt))
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign perf_recover_cnt_o = r_perf_recover_cnt;
    assign perf_stall_cnt_o   = r_perf_stall_cnt;
`endif

endmodule
`default_nettype wire
